// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic: ring constants, zeta table and the
// Montgomery multiply used by the NTT, inverse NTT and basemul stages.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_Q_INV = -3327;

  typedef logic signed [15:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Powers of 17 in Montgomery form, bit-reversed order, centred mod q
  localparam coef_t ZETAS [0:127] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  // Returns x*y*2^-16 mod q, not fully reduced
  function automatic coef_t fqmul(
    input coef_t x,
    input coef_t y,
    input int    q,
    input int    qinv
  );
    logic signed [31:0] p;
    logic signed [31:0] m;
    coef_t t;
    p = x * y;
    m = p * qinv;
    t = m[15:0];
    m = p - t * q;
    return m[31:16];
  endfunction

endpackage

// File: rtl/poly_basemul_if.sv
// Start/done handshake plus whole-polynomial operand and result
// buses between the NTT stage and the basemul stage.
interface poly_basemul_if import kyber_pkg::*; #(
  parameter int N = KYBER_N
) ();

  logic  start;
  logic  acc_en;
  coef_t a_in  [0:N-1];
  coef_t b_in  [0:N-1];
  logic  busy;
  logic  done;
  coef_t r_out [0:N-1];

  modport master (
    output start, acc_en, a_in, b_in,
    input  busy, done, r_out
  );

  modport slave (
    input  start, acc_en, a_in, b_in,
    output busy, done, r_out
  );

endinterface

// File: rtl/basemul_pair.sv
// Degree-1 product of one coefficient pair modulo (X^2 - zeta),
// purely combinational.
module basemul_pair import kyber_pkg::*; #(
  parameter int Q    = KYBER_Q,
  parameter int QINV = KYBER_Q_INV
) (
  input  coef_t a0,
  input  coef_t a1,
  input  coef_t b0,
  input  coef_t b1,
  input  coef_t zeta,
  output coef_t r0,
  output coef_t r1
);

  coef_t hi;

  assign hi = fqmul(a1, b1, Q, QINV);

  assign r0 = fqmul(hi, zeta, Q, QINV)
            + fqmul(a0, b0, Q, QINV);

  assign r1 = fqmul(a0, b1, Q, QINV)
            + fqmul(a1, b0, Q, QINV);

endmodule

// File: rtl/poly_basemul.sv
// NTT-domain pointwise multiply: one coefficient pair per cycle,
// optional accumulation into the held result polynomial.
module poly_basemul #(
  parameter int KYBER_N     = kyber_pkg::KYBER_N,
  parameter int KYBER_Q     = kyber_pkg::KYBER_Q,
  parameter int KYBER_Q_INV = kyber_pkg::KYBER_Q_INV
) (
  input  logic             clk,
  input  logic             rst,
  poly_basemul_if.slave    bus
);

  import kyber_pkg::*;

  localparam int NP = KYBER_N / 2;
  localparam int PW = $clog2(NP);
  localparam int ZB = 64;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] cnt;
  logic          acc_q;
  logic          done_q;
  logic          busy_q;
  logic          accept;
  logic          last;

  coef_t a_q [0:KYBER_N-1];
  coef_t b_q [0:KYBER_N-1];
  coef_t r_q [0:KYBER_N-1];

  logic [PW:0] i0;
  logic [PW:0] i1;
  logic [6:0]  zidx;
  coef_t       zeta;
  coef_t       p0;
  coef_t       p1;

  assign i0   = {cnt, 1'b0};
  assign i1   = {cnt, 1'b1};
  assign last = (cnt == PW'(NP - 1));

  // Two pairs share each zeta, the odd one takes its negation
  assign zidx = 7'(ZB) + 7'(cnt >> 1);
  assign zeta = cnt[0] ? -ZETAS[zidx] : ZETAS[zidx];

  basemul_pair #(
    .Q    (KYBER_Q),
    .QINV (KYBER_Q_INV)
  ) u_pair (
    .a0   (a_q[i0]),
    .a1   (a_q[i1]),
    .b0   (b_q[i0]),
    .b1   (b_q[i1]),
    .zeta (zeta),
    .r0   (p0),
    .r1   (p1)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = COMP;
          accept    = 1'b1;
        end
      end
      COMP: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < KYBER_N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      done_q <= (state == DONE);
      // Busy lags the FSM by a cycle, so it drops with done
      busy_q <= (state != IDLE);
      if (accept) begin
        a_q   <= bus.a_in;
        b_q   <= bus.b_in;
        acc_q <= bus.acc_en;
        cnt   <= '0;
      end
      if (state == COMP) begin
        cnt     <= cnt + PW'(1);
        r_q[i0] <= acc_q ? r_q[i0] + p0 : p0;
        r_q[i1] <= acc_q ? r_q[i1] + p1 : p1;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.r_out = r_q;

endmodule

// File: tb/tb_poly_basemul.sv
// Directed and randomised checks of poly_basemul against
// hand-computed values and an independent reference model.
module tb_poly_basemul;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_basemul_if bus ();

  poly_basemul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] ea [0:255];
  logic signed [15:0] eb [0:255];
  logic signed [15:0] er [0:255];

  task automatic chk(
    input string       tag,
    input int          idx,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got %0d want %0d",
             tag, idx, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 256; i++)
      chk(tag, i, bus.r_out[i], er[i]);
  endtask

  function automatic logic signed [15:0] m_fq(
    input int x,
    input int y
  );
    int p;
    int t;
    int r;
    p = x * y;
    t = p * (-3327);
    t = int'(shortint'(t));
    r = (p - t * 3329) >>> 16;
    return r[15:0];
  endfunction

  // 2^16 * 17^brv7(i) mod q, centred
  function automatic int m_zeta(input int i);
    int br;
    int z;
    br = 0;
    z  = 2285;
    for (int k = 0; k < 7; k++)
      if (i[k]) br |= 1 << (6 - k);
    for (int k = 0; k < br; k++)
      z = (z * 17) % 3329;
    if (z > 1664) z -= 3329;
    return z;
  endfunction

  task automatic model(input bit acc);
    int z;
    logic signed [15:0] r0;
    logic signed [15:0] r1;
    for (int p = 0; p < 128; p++) begin
      z = m_zeta(64 + p / 2);
      if (p % 2 == 1) z = -z;
      r0 = m_fq(m_fq(ea[2*p+1], eb[2*p+1]), z)
         + m_fq(ea[2*p], eb[2*p]);
      r1 = m_fq(ea[2*p], eb[2*p+1])
         + m_fq(ea[2*p+1], eb[2*p]);
      er[2*p]   = acc ? er[2*p] + r0 : r0;
      er[2*p+1] = acc ? er[2*p+1] + r1 : r1;
    end
  endtask

  task automatic run_op(input bit acc, input bit noise);
    int n;
    bus.a_in   = ea;
    bus.b_in   = eb;
    bus.acc_en = acc;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_e0", 0, bus.busy, 0);
    n = 0;
    while (!bus.done && n < 200) begin
      step();
      n++;
      if (n == 1) chk("busy_on", 0, bus.busy, 1);
      if (noise && n < 120) begin
        bus.start  = 1'($urandom);
        bus.acc_en = 1'($urandom);
        bus.a_in[8'($urandom)] = 16'($urandom);
        bus.b_in[8'($urandom)] = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("latency", 0, n, 129);
  endtask

  task automatic end_op();
    step();
    chk("done_fall", 0, bus.done, 0);
    chk("busy_fall", 0, bus.busy, 0);
  endtask

  task automatic set_unit();
    for (int i = 0; i < 256; i++) begin
      ea[i] = (i % 2 == 0) ? 16'sd1 : 16'sd0;
      eb[i] = ea[i];
    end
  endtask

  task automatic exp_unit(input int v);
    for (int i = 0; i < 256; i++)
      er[i] = (i % 2 == 0) ? 16'(v) : 16'sd0;
  endtask

  initial begin
    int nd;
    int lowc;
    int ndone;
    int td [0:2];
    bit acc;

    bus.start  = 1'b0;
    bus.acc_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus.a_in[i] = 16'sd7;
      bus.b_in[i] = -16'sd3;
      er[i]       = '0;
    end

    step();
    step();
    chk("rst_done", 0, bus.done, 0);
    chk("rst_busy", 0, bus.busy, 0);
    chk_all("rst_r");
    rst = 1'b0;
    step();

    set_unit();
    run_op(1'b0, 1'b0);
    exp_unit(169);
    chk_all("unit");
    end_op();

    run_op(1'b1, 1'b0);
    exp_unit(338);
    chk_all("unit_acc");
    end_op();

    for (int i = 0; i < 256; i++) begin
      ea[i] = '0;
      eb[i] = '0;
      er[i] = '0;
    end
    ea[1] = 16'sd1;
    eb[1] = 16'sd1;
    ea[3] = 16'sd1;
    eb[3] = 16'sd1;
    run_op(1'b0, 1'b0);
    er[0] = -16'sd456;
    er[2] = 16'sd456;
    chk_all("zeta");
    end_op();

    for (int i = 0; i < 256; i++)
      bus.a_in[i] = 16'sd99;
    repeat (5) step();
    chk_all("hold");

    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < 256; i++) begin
        ea[i] = 16'($urandom);
        eb[i] = 16'($urandom);
      end
      acc = 1'($urandom);
      run_op(acc, 1'b1);
      model(acc);
      chk_all("rand");
      end_op();
    end

    set_unit();
    bus.a_in   = ea;
    bus.b_in   = eb;
    bus.acc_en = 1'b0;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (60) step();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) er[i] = '0;
    chk_all("abort_r");
    chk("abort_done", 0, bus.done, 0);
    chk("abort_busy", 0, bus.busy, 0);
    step();
    rst = 1'b0;
    ndone = 0;
    repeat (140) begin
      step();
      if (bus.done) ndone++;
    end
    chk("abort_nodone", 0, ndone, 0);
    chk("abort_idle", 0, bus.busy, 0);
    run_op(1'b0, 1'b0);
    exp_unit(169);
    chk_all("restart");
    end_op();

    for (int i = 0; i < 256; i++) begin
      ea[i] = (i % 2 == 0) ? 16'sd1 : 16'sd0;
      eb[i] = (i % 2 == 0) ? 16'sd2 : 16'sd0;
    end
    er[0] = '0;
    bus.a_in   = ea;
    bus.b_in   = eb;
    bus.acc_en = 1'b0;
    bus.start  = 1'b1;
    step();
    nd   = 0;
    lowc = 0;
    for (int k = 1; k < 600; k++) begin
      step();
      if (nd >= 1 && !bus.busy) lowc++;
      if (bus.done) begin
        td[nd] = k;
        nd++;
        if (nd == 3) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    chk("b2b_count", 0, nd, 3);
    chk("b2b_first", 0, td[0], 129);
    chk("b2b_gap1", 0, td[1] - td[0], 130);
    chk("b2b_gap2", 0, td[2] - td[1], 130);
    chk("b2b_busylow", 0, lowc, 2);
    exp_unit(338);
    chk_all("b2b_r");
    end_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_basemul.md
POLY_BASEMUL -- requirements
Module: poly_basemul

Interface
REQ-001 SHALL have parameter KYBER_N, default 256, coefficient count per polynomial.
REQ-002 SHALL have parameter KYBER_Q, default 3329, the modulus.
REQ-003 SHALL have parameter KYBER_Q_INV, default -3327, the Montgomery constant q^-1 mod 2^16, signed.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a new multiply; sampled only in IDLE.
REQ-007 acc_en  input  1  when high at accepted start, add the product into the current r_out contents.
REQ-008 a_in  input  signed 16 x [0:255]  NTT-domain operand A (the NTT stage output).
REQ-009 b_in  input  signed 16 x [0:255]  NTT-domain operand B.
REQ-010 busy  output  1  high from the cycle after start is accepted until done falls.
REQ-011 done  output  1  one-cycle pulse when r_out holds the final result.
REQ-012 r_out  output  signed 16 x [0:255]  registered product in Montgomery form.

Function
REQ-013 fqmul(x,y) SHALL be: p = x*y (32-bit signed); t = low 16 bits of p*KYBER_Q_INV, signed; result = (p - t*KYBER_Q) >>> 16, 16-bit signed.
REQ-014 Pair index p = 0..127 covers coefficients 2p and 2p+1; zeta_p = zetas[64 + p/2] for even p and -zetas[64 + p/2] for odd p.
REQ-015 Per pair: r0 = fqmul(fqmul(a1,b1),zeta_p) + fqmul(a0,b0); r1 = fqmul(a0,b1) + fqmul(a1,b0), where a0 = a[2p], a1 = a[2p+1], and likewise for b.
REQ-016 All additions, including accumulation, SHALL be 16-bit two's-complement wrap with no reduction.
REQ-017 FSM states SHALL be IDLE, COMP and DONE.
REQ-018 IDLE with start=1 -> COMP on that edge; a_in, b_in and acc_en are latched internally; pair counter cleared to 0.
REQ-019 IDLE with start=0 -> stay in IDLE; r_out holds its value and inputs are not sampled.
REQ-020 COMP SHALL process exactly one pair per cycle, in order 0..127, writing r_out[2p] and r_out[2p+1].
REQ-021 With acc_en latched high, each written value SHALL be the old r_out value plus the new product.
REQ-022 COMP -> DONE on the edge that writes pair 127.
REQ-023 DONE -> IDLE, with done registered high for the following single cycle.
REQ-024 Latency: if start is accepted at edge E0, pairs are written at E1..E128, done is high between E129 and E130, and busy falls at E130.
REQ-025 start during COMP or DONE SHALL be ignored; changes to a_in or b_in after acceptance SHALL NOT affect the result.
REQ-026 start held high continuously SHALL be accepted again on the first IDLE cycle after done, i.e. back-to-back operation.
REQ-027 r_out SHALL remain stable from done until the next accepted start.

Reset
REQ-028 On rst: state -> IDLE, pair counter 0, done 0, busy 0, every r_out coefficient 0, latched operands 0, latched acc_en 0.
REQ-029 rst asserted mid-COMP SHALL abort immediately, produce no done pulse, and leave outputs at their reset values.

Structure
REQ-030 A shared package kyber_pkg SHALL hold KYBER_N, KYBER_Q, KYBER_Q_INV, the 128-entry zetas table and the fqmul function, for reuse by the NTT and inverse-NTT stages.
REQ-031 One combinational sub-module basemul_pair SHALL map (a0,a1,b0,b1,zeta) to (r0,r1) per REQ-015.
REQ-032 poly_basemul SHALL contain only the FSM, the pair counter, zeta index and sign selection, and the registers.

Verification
REQ-033 a[2p]=b[2p]=1 and a[2p+1]=b[2p+1]=0 for all p, acc_en=0 -> every even r_out = 169, every odd r_out = 0, done exactly 129 cycles after the start edge.
REQ-034 a[1]=b[1]=1 and a[3]=b[3]=1, all other coefficients 0 -> r_out[0] = -456, r_out[2] = 456, all other coefficients 0.
REQ-035 Repeat the REQ-033 stimulus with acc_en=1 immediately after the first run -> even r_out = 338, odd r_out = 0.
REQ-036 Random a and b over 100 runs -> r_out matches a software basemul reference model bit-exactly; start pulses and input changes during COMP have no effect.
REQ-037 rst pulsed at pair 60 -> all r_out = 0, no done pulse, IDLE; a fresh start afterwards gives a correct result.
REQ-038 start held high for 3 operations -> done pulses spaced exactly 130 cycles apart, busy low for exactly 1 cycle between operations.
